// File: rtl/cla_adder_pkg.sv
// ---------------------------------------------------------------------------
// cla_adder_pkg
// Shared definitions for the 4-bit carry-lookahead adder:
//   CLA_W        - operand width (fixed at 4)
//   cla_result_t - the registered output bundle {cout, sum, grp_p, grp_g}
// ---------------------------------------------------------------------------
package cla_adder_pkg;

   localparam int CLA_W = 4;

   typedef struct packed {
      logic             cout;
      logic [CLA_W-1:0] sum;
      logic             grp_p;
      logic             grp_g;
   } cla_result_t;

endpackage

// File: rtl/cla_adder_if.sv
// ---------------------------------------------------------------------------
// cla_adder_if
// Operand/result bundle for cla_adder.
//   cin, a1..a4, b1..b4  : operands (bit 1 = LSB), driven by the master
//   s1..s4, cout         : registered sum and carry-out, driven by the slave
//   grp_p, grp_g         : registered group propagate / generate
// master = the block supplying operands, slave = the adder itself.
// ---------------------------------------------------------------------------
interface cla_adder_if;

   logic cin;
   logic a1, a2, a3, a4;
   logic b1, b2, b3, b4;
   logic s1, s2, s3, s4;
   logic cout;
   logic grp_p;
   logic grp_g;

   modport master (
      output cin, a1, a2, a3, a4, b1, b2, b3, b4,
      input  s1, s2, s3, s4, cout, grp_p, grp_g
   );

   modport slave (
      input  cin, a1, a2, a3, a4, b1, b2, b3, b4,
      output s1, s2, s3, s4, cout, grp_p, grp_g
   );

endinterface

// File: rtl/cla_pg_bit.sv
// ---------------------------------------------------------------------------
// cla_pg_bit
// Per-bit propagate/generate cell.
//   i_a, i_b : operand bits
//   o_p      : propagate, i_a ^ i_b
//   o_g      : generate,  i_a & i_b
// ---------------------------------------------------------------------------
module cla_pg_bit (
   input  logic i_a,
   input  logic i_b,
   output logic o_p,
   output logic o_g
);

   assign o_p = i_a ^ i_b;
   assign o_g = i_a & i_b;

endmodule

// File: rtl/cla_adder.sv
// ---------------------------------------------------------------------------
// cla_adder
// 4-bit carry-lookahead adder with a single output register stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all outputs immediately
//   bus   : cla_adder_if.slave - operands in, registered sum/cout/grp_p/grp_g
// Result {cout,s4..s1} = A + B + cin, one clock of latency, one add per clock.
// ---------------------------------------------------------------------------
module cla_adder
   import cla_adder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   cla_adder_if.slave  bus
);

   logic [CLA_W-1:0] w_a;
   logic [CLA_W-1:0] w_b;
   logic [CLA_W-1:0] w_p;
   logic [CLA_W-1:0] w_g;
   logic             w_c1, w_c2, w_c3, w_c4, w_c5;
   logic             w_grp_p;
   logic             w_grp_g;
   cla_result_t      w_res_next;
   cla_result_t      r_res;

   assign w_a = {bus.a4, bus.a3, bus.a2, bus.a1};
   assign w_b = {bus.b4, bus.b3, bus.b2, bus.b1};

   generate
      for (genvar gi = 0; gi < CLA_W; gi++) begin : g_pg
         cla_pg_bit u_pg (
            .i_a (w_a[gi]),
            .i_b (w_b[gi]),
            .o_p (w_p[gi]),
            .o_g (w_g[gi])
         );
      end
   endgenerate

   // Every carry is a flat sum-of-products of p/g/cin so no carry depends on
   // another carry; w_p[0]/w_g[0] are bit 1 (LSB).
   assign w_c1 = bus.cin;
   assign w_c2 = w_g[0]
               | (w_p[0] & bus.cin);
   assign w_c3 = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & bus.cin);
   assign w_c4 = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & bus.cin);
   assign w_c5 = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bus.cin);

   // Group terms for a second-level lookahead unit: grp_g is c5 with cin = 0.
   assign w_grp_p = &w_p;
   assign w_grp_g = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

   assign w_res_next.cout  = w_c5;
   assign w_res_next.sum   = w_p ^ {w_c4, w_c3, w_c2, w_c1};
   assign w_res_next.grp_p = w_grp_p;
   assign w_res_next.grp_g = w_grp_g;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res <= '0;
      end else begin
         r_res <= w_res_next;
      end
   end

   assign bus.s1    = r_res.sum[0];
   assign bus.s2    = r_res.sum[1];
   assign bus.s3    = r_res.sum[2];
   assign bus.s4    = r_res.sum[3];
   assign bus.cout  = r_res.cout;
   assign bus.grp_p = r_res.grp_p;
   assign bus.grp_g = r_res.grp_g;

endmodule

// File: tb/tb_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_adder
// Self-checking bench for cla_adder. Expected values come from plain integer
// addition of the operands; outputs are sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_cla_adder;
   import cla_adder_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [6:0] exp_vec;   // {cout, s[3:0], grp_p, grp_g}
   logic [6:0] obs_vec;

   cla_adder_if bus ();

   cla_adder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: plain unsigned arithmetic, not gate equations.
   function automatic logic [6:0] ref_model(input logic [3:0] a, input logic [3:0] b, input logic c);
      logic [4:0] total;
      logic       gp;
      logic       gg;
      total = 5'(a) + 5'(b) + 5'(c);
      gp    = ((a ^ b) == 4'hF);
      gg    = ((int'(a) + int'(b)) > 15);
      return {total, gp, gg};
   endfunction

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
      bus.a1 = a[0]; bus.a2 = a[1]; bus.a3 = a[2]; bus.a4 = a[3];
      bus.b1 = b[0]; bus.b2 = b[1]; bus.b3 = b[2]; bus.b4 = b[3];
      bus.cin = c;
   endtask

   task automatic check(input string tag, input logic [6:0] expected);
      obs_vec = {bus.cout, bus.s4, bus.s3, bus.s2, bus.s1, bus.grp_p, bus.grp_g};
      checks++;
      assert (obs_vec === expected) else begin
         errors++;
         $error("FAIL %s observed={cout,s,gp,gg}=%b expected=%b", tag, obs_vec, expected);
      end
   endtask

   // Drive at the falling edge, check 1 unit after the next rising edge.
   task automatic add_and_check(input string tag, input logic [3:0] a, input logic [3:0] b, input logic c);
      @(negedge clk);
      drive(a, b, c);
      exp_vec = ref_model(a, b, c);
      @(posedge clk);
      #1;
      check(tag, exp_vec);
   endtask

   initial begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive(4'hF, 4'hF, 1'b1);

      // Reset held with random inputs and the clock running.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(4'($urandom), 4'($urandom), 1'($urandom));
         @(posedge clk);
         #1;
         check("reset_hold", 7'b0);
      end

      // Release, then directed cases.
      @(negedge clk);
      rst_n = 1'b1;
      add_and_check("saturate", 4'b1111, 4'b1111, 1'b1);
      check("saturate_const", 7'b1_1111_0_1);
      add_and_check("prop_chain", 4'b1010, 4'b0101, 1'b1);
      check("prop_chain_const", 7'b1_0000_1_0);
      add_and_check("zero", 4'b0000, 4'b0000, 1'b0);
      check("zero_const", 7'b0);
      add_and_check("identity", 4'b0110, 4'b0000, 1'b0);
      check("identity_const", 7'b0_0110_0_0);

      // Toggling LSB of A with B = 1111, cin = 1.
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            add_and_check("toggle_1110", 4'b1110, 4'b1111, 1'b1);
            check("toggle_1110_const", 7'b1_1110_0_1);
         end else begin
            add_and_check("toggle_1111", 4'b1111, 4'b1111, 1'b1);
            check("toggle_1111_const", 7'b1_1111_0_1);
         end
      end

      // Mid-cycle asynchronous reset: outputs must clear before the next edge.
      add_and_check("pre_reset", 4'b1001, 4'b0111, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear", 7'b0);
      @(posedge clk);
      #1;
      check("async_hold", 7'b0);
      @(negedge clk);
      rst_n = 1'b1;
      add_and_check("post_reset", 4'b0011, 4'b0100, 1'b0);

      // Exhaustive sweep, one add per clock.
      for (int v = 0; v < 512; v++) begin
         add_and_check("sweep", 4'(v >> 5), 4'(v >> 1), 1'(v));
      end

      // Random vectors.
      for (int i = 0; i < 200; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         rc = 1'($urandom_range(1, 0));
         add_and_check("random", ra, rb, rc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
